// File: rtl/regbus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : regbus_arbiter_if                                          |
// | Brief   : Request/grant and write-bus bundle between the four        |
// |           requesters and the register-file write arbiter.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface regbus_arbiter_if #(
    parameter int DATAWIDTH = 16
);
    logic [3:0]           req;
    logic [3:0]           last;
    logic [DATAWIDTH-1:0] din0;
    logic [DATAWIDTH-1:0] din1;
    logic [DATAWIDTH-1:0] din2;
    logic [DATAWIDTH-1:0] din3;
    logic [3:0]           gnt;
    logic [1:0]           cntrl;
    logic                 wr_en;
    logic [DATAWIDTH-1:0] dout;
    logic                 busy;

    // Requester side: drives requests and data, observes grants and writes.
    modport master (
        output req, last, din0, din1, din2, din3,
        input  gnt, cntrl, wr_en, dout, busy
    );

    // Arbiter side.
    modport slave (
        input  req, last, din0, din1, din2, din3,
        output gnt, cntrl, wr_en, dout, busy
    );
endinterface
`default_nettype wire

// File: rtl/regbus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : regbus_arbiter                                             |
// | Brief   : Round-robin arbiter for the register-file write bus with   |
// |           capped bursts, registered grant/select and write strobe.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regbus_arbiter #(
    parameter int DATAWIDTH = 16,
    parameter int MAXBURST  = 4
) (
    input  logic             clk,
    input  logic             reset,
    regbus_arbiter_if.slave  bus
);

    localparam logic [3:0] c_MAXBURST = 4'(MAXBURST);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_gnt;
    logic [3:0]           w_gnt_nxt;
    logic [1:0]           r_cntrl;
    logic [1:0]           w_cntrl_nxt;
    logic                 r_wr_en;
    logic                 w_wr_en_nxt;
    logic [DATAWIDTH-1:0] r_dout;
    logic [DATAWIDTH-1:0] w_dout_nxt;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_nxt;
    logic [1:0]           r_ptr;
    logic [1:0]           w_ptr_nxt;

    logic [1:0]           w_winner;
    logic                 w_any_req;
    logic                 w_beat;
    logic                 w_rearb;
    logic [3:0]           w_cnt_inc;
    logic [DATAWIDTH-1:0] w_din_sel;

    assign w_any_req = |bus.req;
    assign w_beat    = bus.req[r_cntrl];
    assign w_cnt_inc = r_cnt + 4'd1;

    // Select the data of the currently granted requester.
    always_comb begin
        w_din_sel = bus.din0;
        case (r_cntrl)
            2'd0:    w_din_sel = bus.din0;
            2'd1:    w_din_sel = bus.din1;
            2'd2:    w_din_sel = bus.din2;
            default: w_din_sel = bus.din3;
        endcase
    end

    // Round-robin search: first asserted req after the last-served index,
    // the last-served requester itself being the lowest priority.
    always_comb begin
        w_winner = r_ptr;
        for (int k = 4; k >= 1; k--) begin
            if (bus.req[r_ptr + 2'(k)]) begin
                w_winner = r_ptr + 2'(k);
            end
        end
    end

    // Next-state and next-output logic; a grant ends on last, burst cap or
    // dropped request, and re-arbitration happens in that same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_cntrl_nxt = r_cntrl;
        w_wr_en_nxt = 1'b0;
        w_dout_nxt  = r_dout;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_rearb     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_rearb = 1'b1;
            end
            S_GRANT: begin
                if (w_beat) begin
                    w_wr_en_nxt = 1'b1;
                    w_dout_nxt  = w_din_sel;
                    w_cnt_nxt   = w_cnt_inc;
                    if (bus.last[r_cntrl] || (w_cnt_inc == c_MAXBURST)) begin
                        w_rearb = 1'b1;
                    end
                end else begin
                    w_rearb = 1'b1;
                end
            end
            default: begin
                w_rearb = 1'b1;
            end
        endcase

        if (w_rearb) begin
            if (w_any_req) begin
                w_state_nxt = S_GRANT;
                w_gnt_nxt   = 4'b0001 << w_winner;
                w_cntrl_nxt = w_winner;
                w_ptr_nxt   = w_winner;
                w_cnt_nxt   = 4'd0;
            end else begin
                // cntrl deliberately keeps its last value when idle.
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 4'b0000;
            end
        end
    end

    // State and output registers; reset drops any in-flight beat at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_gnt   <= 4'b0000;
            r_cntrl <= 2'd0;
            r_wr_en <= 1'b0;
            r_dout  <= '0;
            r_cnt   <= 4'd0;
            r_ptr   <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cntrl <= w_cntrl_nxt;
            r_wr_en <= w_wr_en_nxt;
            r_dout  <= w_dout_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.cntrl = r_cntrl;
    assign bus.wr_en = r_wr_en;
    assign bus.dout  = r_dout;
    assign bus.busy  = (r_state == S_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_regbus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_regbus_arbiter                                          |
// | Brief   : Self-checking bench for regbus_arbiter: directed vector    |
// |           table, reset corner case and random traffic vs a model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_regbus_arbiter;

    localparam int c_MAXB = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  t_req;
    logic [3:0]  t_last;
    logic [15:0] tdin [4];

    int total;
    int bad;

    regbus_arbiter_if #(.DATAWIDTH(16)) bus ();

    assign bus.req  = t_req;
    assign bus.last = t_last;
    assign bus.din0 = tdin[0];
    assign bus.din1 = tdin[1];
    assign bus.din2 = tdin[2];
    assign bus.din3 = tdin[3];

    regbus_arbiter #(.DATAWIDTH(16), .MAXBURST(c_MAXB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    int          m_owner;   // -1 when nobody holds the bus
    int          m_ptr;
    int          m_beats;
    int          m_cntrl;
    logic [3:0]  e_gnt;
    logic [1:0]  e_cntrl;
    logic        e_wr;
    logic [15:0] e_dout;
    logic        e_busy;

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_publish();
        e_gnt   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e_cntrl = 2'(m_cntrl);
        e_busy  = (m_owner >= 0);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_beats = 0;
        m_cntrl = 0;
        e_wr    = 1'b0;
        e_dout  = 16'h0000;
        model_publish();
    endtask

    task automatic model_step();
        bit done;
        int w;
        e_wr = 1'b0;
        done = 1'b1;
        if (m_owner >= 0 && t_req[m_owner]) begin
            e_wr    = 1'b1;
            e_dout  = tdin[m_owner];
            m_beats = m_beats + 1;
            done    = t_last[m_owner] || (m_beats == c_MAXB);
        end
        if (done) begin
            w = rr_pick(t_req, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = w;
                m_cntrl = w;
                m_beats = 0;
            end else begin
                m_owner = -1;
            end
        end
        model_publish();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic apply(input logic [3:0] r, input logic [3:0] l);
        t_req  = r;
        t_last = l;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        t_req  = 4'b0000;
        t_last = 4'b0000;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_model(input string name);
        total++;
        if (bus.gnt !== e_gnt || bus.cntrl !== e_cntrl || bus.wr_en !== e_wr ||
            bus.dout !== e_dout || bus.busy !== e_busy) begin
            bad++;
            $display("FAIL %s: got gnt=%b cntrl=%0d wr=%b dout=%h busy=%b, want gnt=%b cntrl=%0d wr=%b dout=%h busy=%b",
                     name, bus.gnt, bus.cntrl, bus.wr_en, bus.dout, bus.busy,
                     e_gnt, e_cntrl, e_wr, e_dout, e_busy);
        end
    endtask

    task automatic check_const(input string name, input logic [3:0] g, input logic [1:0] c,
                               input logic w, input logic [15:0] d, input logic b);
        total++;
        if (bus.gnt !== g || bus.cntrl !== c || bus.wr_en !== w ||
            bus.dout !== d || bus.busy !== b) begin
            bad++;
            $display("FAIL %s: got gnt=%b cntrl=%0d wr=%b dout=%h busy=%b, want gnt=%b cntrl=%0d wr=%b dout=%h busy=%b",
                     name, bus.gnt, bus.cntrl, bus.wr_en, bus.dout, bus.busy, g, c, w, d, b);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [3:0]  req;
        logic [3:0]  last;
        logic [3:0]  gnt;
        logic [1:0]  cntrl;
        logic        wr;
        logic [15:0] dout;
    } vec_t;

    localparam int c_NVEC = 26;
    vec_t vecs [c_NVEC];

    initial begin
        total = 0;
        bad   = 0;
        tdin[0] = 16'hA5A5;
        tdin[1] = 16'h1111;
        tdin[2] = 16'h2222;
        tdin[3] = 16'h3333;

        // single request, then round robin, burst cap, early drop, wrap-around
        vecs[0]  = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b0, 16'h0000};
        vecs[1]  = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 16'hA5A5};
        vecs[2]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 16'hA5A5};
        vecs[3]  = '{4'b1111, 4'b1111, 4'b0010, 2'd1, 1'b0, 16'hA5A5};
        vecs[4]  = '{4'b1111, 4'b1111, 4'b0100, 2'd2, 1'b1, 16'h1111};
        vecs[5]  = '{4'b1111, 4'b1111, 4'b1000, 2'd3, 1'b1, 16'h2222};
        vecs[6]  = '{4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 16'h3333};
        vecs[7]  = '{4'b1111, 4'b1111, 4'b0010, 2'd1, 1'b1, 16'hA5A5};
        vecs[8]  = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 16'hA5A5};
        vecs[9]  = '{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0, 16'hA5A5};
        vecs[10] = '{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 16'hA5A5};
        vecs[11] = '{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 16'hA5A5};
        vecs[12] = '{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 16'hA5A5};
        vecs[13] = '{4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 16'hA5A5};
        vecs[14] = '{4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 16'h1111};
        vecs[15] = '{4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 16'h1111};
        vecs[16] = '{4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 16'h1111};
        vecs[17] = '{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 16'h1111};
        vecs[18] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 16'h1111};
        vecs[19] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 16'h1111};
        vecs[20] = '{4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, 16'h1111};
        vecs[21] = '{4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 16'h1111};
        vecs[22] = '{4'b1001, 4'b1001, 4'b0001, 2'd0, 1'b0, 16'h1111};
        vecs[23] = '{4'b1001, 4'b1001, 4'b1000, 2'd3, 1'b1, 16'hA5A5};
        vecs[24] = '{4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 16'h3333};
        vecs[25] = '{4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 16'h3333};

        do_reset();
        check_const("reset_state", 4'b0000, 2'd0, 1'b0, 16'h0000, 1'b0);

        for (int i = 0; i < c_NVEC; i++) begin
            apply(vecs[i].req, vecs[i].last);
            check_const($sformatf("vec[%0d]", i), vecs[i].gnt, vecs[i].cntrl,
                        vecs[i].wr, vecs[i].dout, (vecs[i].gnt != 4'b0000));
        end

        // Reset in the middle of requester 1's second beat.
        do_reset();
        apply(4'b0010, 4'b0000);
        check_const("rst_burst_grant", 4'b0010, 2'd1, 1'b0, 16'h0000, 1'b1);
        apply(4'b0010, 4'b0000);
        check_const("rst_burst_beat1", 4'b0010, 2'd1, 1'b1, 16'h1111, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_const("rst_async_clear", 4'b0000, 2'd0, 1'b0, 16'h0000, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(4'b0010, 4'b0000);
        check_const("rst_regrant", 4'b0010, 2'd1, 1'b0, 16'h0000, 1'b1);
        check_model("rst_regrant_model");

        // Random traffic against the reference model.
        do_reset();
        check_model("rand_reset");
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] r;
            logic [3:0] l;
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : t_req;
            l = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            for (int j = 0; j < 4; j++) tdin[j] = 16'($urandom);
            apply(r, l);
            check_model($sformatf("rand[%0d]", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regbus_arbiter.md
# regbus_arbiter

Round-robin arbiter that shares the register-file write bus among four requesters: ALU, memory load unit, I/O port and immediate path. It drives the 2-bit select of the 4:1 16-bit bus mux, returns one-hot grants, and emits a registered write strobe with data for the register file. Bursts are allowed but capped, so no requester can hold the bus indefinitely.

## Interface
- DATAWIDTH, 16, bus data width (matches `DATAWIDTH).
- MAXBURST, 4, maximum beats per grant before forced rotation (1..15).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  4  per-requester request. Held high while the requester has data.
- last  in  4  per-requester end-of-burst flag. Qualifies the current beat.
- din0..din3  in  DATAWIDTH each  requester data. Internally routed as mux arg0..arg3.
- gnt  out  4  one-hot grant, registered.
- cntrl  out  2  mux select, registered. Equals the index of the active grant.
- wr_en  out  1  register-file write strobe, registered.
- dout  out  DATAWIDTH  registered mux output presented to the register file.
- busy  out  1  high while in GRANT.

## Operation
- Reset values (asynchronous): state=IDLE, gnt=0, cntrl=0, wr_en=0, dout=0, busy=0, beat count=0, last-served pointer=3. With the pointer at 3, requester 0 has first priority.
- States:
  - IDLE: no grant. If any req is high, pick the winner and go to GRANT.
  - GRANT: one gnt bit high.
- Winner selection: the first asserted req searching upward from (pointer+1) mod 4, wrapping 3→0. When a grant is issued, pointer ← winner.
- Beat: a cycle in GRANT where req[cntrl]=1. Each beat captures din[cntrl] and increments the beat count.
- Leaving GRANT: the grant ends after a beat that meets any of the following:
  - last[cntrl]=1;
  - the beat count reaches MAXBURST;
  - req[cntrl] is sampled low (no beat that cycle).
- After the grant ends:
  - If any req is high, re-arbitrate in the same cycle and go directly to GRANT for the next winner, with no idle bubble. The winner may be the same requester only if no other req is high.
  - Otherwise go to IDLE, with gnt=0 and cntrl holding its last value.
- The beat count clears on every new grant.
- Requests from non-granted requesters are ignored until arbitration; they must hold req.
- Deasserting req[i] while granted ends the grant with no write.
- A req/last change on a non-granted line has no effect.
- Reset mid-burst: all outputs clear immediately. Any in-flight beat is dropped and no wr_en follows.

## Timing
- Arbitration latency: req rises at edge N, so gnt/cntrl are valid after edge N+1. The first beat can occur in cycle N+1.
- Data latency: a beat in cycle k produces wr_en=1 and dout=din[cntrl] after edge k+1, for exactly one cycle per beat.
- Back-to-back beats give continuous wr_en. The maximum rate is one write per clock, including across grant handover.
- gnt and cntrl change only on clock edges and are never glitched. At most one gnt bit is high.
- A full burst of B beats takes B cycles of GRANT. The next requester's gnt appears the edge after the final beat.

## Test plan
- Reset/single request: after reset, raise req=0001 with din0=16'hA5A5 and last=0001. Required: gnt=0001 and cntrl=0 one cycle later. Then wr_en=1 and dout=A5A5 the following cycle, then IDLE with gnt=0.
- Round-robin fairness: hold req=1111 with last=1111. Required: grants in order 0,1,2,3,0,… with no gap in wr_en. dout matches each requester's din.
- Burst cap: MAXBURST=4, req=0011, last=0. Required: requester 0 gets exactly 4 beats, then requester 1 gets 4 beats, then 0 again.
- Early drop: grant requester 2, then drop req[2] before any beat while req[3]=1. Required: no wr_en for requester 2, and gnt=1000 on the next edge.
- Reset mid-burst: assert reset asynchronously during the 2nd beat of requester 1. Required: wr_en, gnt and dout go to 0 immediately. After release with req=0010, requester 1 is regranted because the pointer is 3 and 0 is idle.
- Wrap-around: with the pointer at 3, raise req=1001. Required: requester 0 wins, and requester 3 is granted next.
